stripe_scan_sequencer: RTL and testbench

- Sequences the colourful-stripes pixel datapath: generates 640x480@60 Hz (25.175 MHz pixel clock) raster timing.
- Schedules horizontally scrolling colour stripes by emitting a stripe colour index per pixel plus a per-frame scroll offset.
- Sits between the top-level inputs (enable, pause, speed) and the palette/RGB output stage that drives uo_out.

---
 rtl/stripe_scan_sequencer.sv | 104 ++++++++++
 tb/tb_stripe_scan_sequencer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/stripe_scan_sequencer.sv
// Raster timing generator for the scrolling colour-stripe pixel path.
// Produces sync/visible-area decode, a frame-start pulse, a per-pixel stripe
// colour index and a per-frame scroll offset. All outputs are registered and
// derived from next-state values so they stay aligned with hpos/vpos.
module stripe_scan_sequencer #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int STRIPE_W_LOG2 = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       pause,
    input  logic [3:0] speed,
    output logic       hsync,
    output logic       vsync,
    output logic       display_on,
    output logic [9:0] hpos,
    output logic [9:0] vpos,
    output logic       frame_start,
    output logic [2:0] stripe_idx,
    output logic [9:0] scroll
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic       h_wrap;
    logic       v_wrap;
    logic [9:0] h_next;
    logic [9:0] v_next;
    logic [9:0] s_next;
    logic [9:0] pix_next;
    logic       hs_next;
    logic       vs_next;
    logic       disp_next;
    logic       fs_next;
    logic [2:0] stripe_next;

    // Next counter/scroll values and the output decode taken from them.
    always_comb begin
        h_wrap = (hpos == H_LAST);
        v_wrap = (vpos == V_LAST);

        h_next = h_wrap ? '0 : hpos + 10'd1;

        v_next = vpos;
        if (h_wrap) begin
            v_next = v_wrap ? '0 : vpos + 10'd1;
        end

        s_next = scroll;
        if (h_wrap && v_wrap && !pause) begin
            s_next = scroll + {6'd0, speed};
        end

        hs_next   = !((h_next >= HS_FIRST) && (h_next <= HS_LAST));
        vs_next   = !((v_next >= VS_FIRST) && (v_next <= VS_LAST));
        disp_next = (h_next < H_VIS) && (v_next < V_VIS);
        fs_next   = (h_next == '0) && (v_next == '0);

        pix_next    = h_next + s_next;
        stripe_next = disp_next ? pix_next[STRIPE_W_LOG2 +: 3] : '0;
    end

    // State and output registers; en=0 freezes everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hpos        <= H_LAST;
            vpos        <= V_LAST;
            scroll      <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_on  <= 1'b0;
            frame_start <= 1'b0;
            stripe_idx  <= '0;
        end else if (en) begin
            hpos        <= h_next;
            vpos        <= v_next;
            scroll      <= s_next;
            hsync       <= hs_next;
            vsync       <= vs_next;
            display_on  <= disp_next;
            frame_start <= fs_next;
            stripe_idx  <= stripe_next;
        end
    end

endmodule

// File: tb/tb_stripe_scan_sequencer.sv
// Self-checking bench for stripe_scan_sequencer using a shrunken raster so
// whole frames (and many scroll updates) fit in a short run.
module tb_stripe_scan_sequencer;

    localparam int HA = 64, HF = 4, HS = 8, HB = 4;
    localparam int VA = 2,  VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 80
    localparam int VT = VA + VF + VS + VB;   // 6
    localparam int FR = HT * VT;             // 480

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       pause = 1'b0;
    logic [3:0] speed = 4'd0;
    logic       hsync, vsync, display_on, frame_start;
    logic [9:0] hpos, vpos, scroll;
    logic [2:0] stripe_idx;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Reference model state
    int m_h = HT - 1;
    int m_v = VT - 1;
    int m_s = 0;

    logic [36:0] exp_q[$];

    localparam logic [36:0] RST_VEC = {1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 10'(HT - 1), 10'(VT - 1), 10'd0};

    stripe_scan_sequencer #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .STRIPE_W_LOG2(5)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .pause(pause), .speed(speed),
        .hsync(hsync), .vsync(vsync), .display_on(display_on),
        .hpos(hpos), .vpos(vpos), .frame_start(frame_start),
        .stripe_idx(stripe_idx), .scroll(scroll)
    );

    always #20 clk = ~clk;

    initial begin
        #(150000 * 40);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [36:0] dut_vec();
        return {hsync, vsync, display_on, frame_start, stripe_idx, hpos, vpos, scroll};
    endfunction

    // Expected output word for a model position, straight from the decode rules.
    function automatic logic [36:0] model_vec(input int h, input int v, input int s);
        logic       hs, vs, d, fs;
        logic [2:0] st;
        hs = !(h >= HA + HF && h < HA + HF + HS);
        vs = !(v >= VA + VF && v < VA + VF + VS);
        d  = (h < HA) && (v < VA);
        fs = (h == 0) && (v == 0);
        st = d ? 3'((((h + s) % 1024) / 32) % 8) : 3'd0;
        return {hs, vs, d, fs, st, 10'(h), 10'(v), 10'(s)};
    endfunction

    task automatic tick();
        logic [36:0] expv;
        if (en) begin
            if (m_h == HT - 1) begin
                m_h = 0;
                if (m_v == VT - 1) begin
                    m_v = 0;
                    if (!pause) m_s = (m_s + int'(speed)) % 1024;
                end else begin
                    m_v = m_v + 1;
                end
            end else begin
                m_h = m_h + 1;
            end
        end
        exp_q.push_back(model_vec(m_h, m_v, m_s));
        @(posedge clk);
        #1;
        cyc++;
        expv = exp_q.pop_front();
        check("pixel", dut_vec(), expv);
    endtask

    task automatic run_until(input int h, input int v, input int budget);
        int n = 0;
        while (!(m_h == h && m_v == v) && n < budget) begin
            tick();
            n++;
        end
        check("reach_pos", 64'(n < budget), 64'd1);
    endtask

    task automatic next_frame();
        tick();
        run_until(0, 0, FR + 2);
    endtask

    initial begin
        int hs_low, vs_low, fs_cnt, fs_last, disp_bad;

        #50;
        check("reset_vec", dut_vec(), RST_VEC);
        rst_n = 1'b1;
        en    = 1'b1;
        speed = 4'd0;

        // First edge lands on (0,0)
        tick();
        check("fs_first", frame_start, 1);
        check("hpos_first", hpos, 0);
        check("vpos_first", vpos, 0);
        check("disp_first", display_on, 1);
        check("stripe_first", stripe_idx, 0);
        check("syncs_first", {hsync, vsync}, 2'b11);
        tick();
        check("fs_second", frame_start, 0);

        // One line: hsync width and line wrap
        hs_low = 0;
        for (int i = 0; i < HT - 2; i++) begin
            tick();
            if (!hsync) hs_low++;
        end
        tick();
        if (!hsync) hs_low++;
        check("hsync_width", hs_low, HS);
        check("line_wrap_h", hpos, 0);
        check("line_wrap_v", vpos, 1);

        // Two frames: vsync width, frame period, blanking lines
        vs_low = 0; fs_cnt = 0; fs_last = -1; disp_bad = 0;
        for (int i = 0; i < 2 * FR; i++) begin
            tick();
            if (!vsync) vs_low++;
            if (vpos >= 10'(VA) && display_on) disp_bad++;
            if (frame_start) begin
                if (fs_last >= 0) check("frame_period", cyc - fs_last, FR);
                fs_last = cyc;
                fs_cnt++;
            end
        end
        check("vsync_width", vs_low, 2 * VS * HT);
        check("frame_pulses", fs_cnt, 2);
        check("blank_lines", disp_bad, 0);

        // Scroll stepping
        speed = 4'd3;
        for (int k = 1; k <= 3; k++) begin
            next_frame();
            check("scroll_step", scroll, 3 * k);
        end
        run_until(22, 0, FR);
        check("stripe_edge_lo", stripe_idx, 0);
        tick();
        check("stripe_edge_hi", stripe_idx, 1);

        // Pause holds scroll across a wrap
        pause = 1'b1;
        next_frame();
        check("pause_hold", scroll, 9);
        pause = 1'b0;

        // Mid-frame speed change only takes effect at the wrap
        run_until(10, 1, FR);
        speed = 4'd7;
        run_until(HT - 1, VT - 1, FR);
        check("speed_midframe", scroll, 9);
        tick();
        check("speed_change", scroll, 16);

        // Preload to 1022 then wrap past 1023
        for (int k = 0; k < 100 && m_s != 1022; k++) begin
            speed = (1022 - m_s) > 15 ? 4'd15 : 4'(1022 - m_s);
            next_frame();
        end
        check("preload", scroll, 1022);
        speed = 4'd3;
        next_frame();
        check("scroll_wrap", scroll, 1);

        // Clock-enable freeze and resume
        run_until(30, 1, FR);
        en = 1'b0;
        repeat (10) tick();
        check("hold_h", hpos, 30);
        check("hold_v", vpos, 1);
        en = 1'b1;
        tick();
        check("resume_h", hpos, 31);

        // Asynchronous reset mid-frame, no clock edge needed
        run_until(40, 1, FR);
        #5;
        rst_n = 1'b0;
        #1;
        check("async_reset", dut_vec(), RST_VEC);
        m_h = HT - 1; m_v = VT - 1; m_s = 0;
        @(posedge clk);
        #1;
        check("reset_held", dut_vec(), RST_VEC);
        rst_n = 1'b1;
        speed = 4'd5;
        tick();
        check("post_reset_fs", frame_start, 1);
        check("post_reset_scroll", scroll, 5);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
